// File: rtl/vga_pattern_gen.sv
// VGA timing and test-pattern generator with an internal pixel-clock divider and frame-latched mode.
// Optional build macro VGA_PATTERN_SCROLL_EN scrolls the checker and gradient patterns by one pixel per frame.
module vga_pattern_gen #(
   parameter int CLK_DIV     = 4,
   parameter int COLOR_BITS  = 4,
   parameter int H_DISPLAY   = 640,
   parameter int H_FRONT     = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BACK      = 48,
   parameter int V_DISPLAY   = 480,
   parameter int V_FRONT     = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BACK      = 33,
   parameter int HSYNC_POL   = 0,
   parameter int VSYNC_POL   = 0,
   parameter int CHECK_SHIFT = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [1:0]            mode,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  display_on,
   output logic [9:0]            hpos,
   output logic [9:0]            vpos,
   output logic [COLOR_BITS-1:0] red,
   output logic [COLOR_BITS-1:0] green,
   output logic [COLOR_BITS-1:0] blue,
   output logic                  frame_start
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]            H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]            V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]            H_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0]            V_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0]            H_EDGE   = 10'(H_DISPLAY - 1);
   localparam logic [9:0]            V_EDGE   = 10'(V_DISPLAY - 1);
   localparam logic [9:0]            HS_BEG   = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0]            HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]            VS_BEG   = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0]            VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
   localparam logic [9:0]            BAR_W    = 10'(H_DISPLAY / 8);
   localparam logic [COLOR_BITS-1:0] C_MAX    = '1;
   localparam logic                  HS_ACT   = 1'(HSYNC_POL);
   localparam logic                  VS_ACT   = 1'(VSYNC_POL);

   // Clamp the colour-bar index so columns past the eighth bar stay white.
   function automatic logic [2:0] sat_bar(input logic [9:0] idx);
      return (idx > 10'd7) ? 3'd7 : idx[2:0];
   endfunction

   function automatic logic [COLOR_BITS-1:0] fill(input logic on);
      return on ? C_MAX : '0;
   endfunction

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic [1:0]       mode_q;
   logic             tick;
   logic             last_h;
   logic             last_v;

   assign tick   = (div_cnt == DIV_LAST);
   assign last_h = (h_cnt == H_LAST);
   assign last_v = (v_cnt == V_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   // Mode only changes on the tick that wraps to (0,0), so a frame never mixes patterns.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt  <= '0;
         v_cnt  <= '0;
         mode_q <= 2'd0;
      end else if (tick) begin
         if (last_h) begin
            h_cnt <= '0;
            if (last_v) begin
               v_cnt  <= '0;
               mode_q <= mode;
            end else begin
               v_cnt <= v_cnt + 10'd1;
            end
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   logic [9:0] x_p0;

`ifdef VGA_PATTERN_SCROLL_EN
   logic [7:0] frame_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt <= 8'd0;
      end else if (tick && last_h && last_v) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   assign x_p0 = h_cnt + {2'b00, frame_cnt};
`else
   assign x_p0 = h_cnt;
`endif

   // ---- stage p0: decode the current counter state into sync and pixel colour ----
   logic                  vis_p0;
   logic                  hs_p0;
   logic                  vs_p0;
   logic [2:0]            bar_p0;
   logic [COLOR_BITS-1:0] red_p0;
   logic [COLOR_BITS-1:0] green_p0;
   logic [COLOR_BITS-1:0] blue_p0;
   logic                  unused_x;

   assign unused_x = ^x_p0;

   always_comb begin
      vis_p0   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_p0    = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
      vs_p0    = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
      bar_p0   = sat_bar(h_cnt / BAR_W);
      red_p0   = '0;
      green_p0 = '0;
      blue_p0  = '0;
      case (mode_q)
         2'd0: begin
            red_p0   = fill(bar_p0[0]);
            green_p0 = fill(bar_p0[1]);
            blue_p0  = fill(bar_p0[2]);
         end
         2'd1: begin
            red_p0   = fill(x_p0[CHECK_SHIFT] ^ v_cnt[CHECK_SHIFT]);
            green_p0 = red_p0;
            blue_p0  = red_p0;
         end
         2'd2: begin
            red_p0   = x_p0[COLOR_BITS+3:4];
            green_p0 = v_cnt[COLOR_BITS+3:4];
            blue_p0  = red_p0 ^ green_p0;
         end
         default: begin
            red_p0   = fill((h_cnt[3:0] == 4'd0) || (v_cnt[3:0] == 4'd0) ||
                            (h_cnt == H_EDGE) || (v_cnt == V_EDGE));
            green_p0 = red_p0;
            blue_p0  = red_p0;
         end
      endcase
      if (!vis_p0) begin
         red_p0   = '0;
         green_p0 = '0;
         blue_p0  = '0;
      end
   end

   // ---- stage p1: registered outputs, one pixel behind the counters ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync       <= ~HS_ACT;
         vsync       <= ~VS_ACT;
         display_on  <= 1'b0;
         hpos        <= '0;
         vpos        <= '0;
         red         <= '0;
         green       <= '0;
         blue        <= '0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= tick && (h_cnt == 10'd0) && (v_cnt == 10'd0);
         if (tick) begin
            hsync      <= hs_p0 ? HS_ACT : ~HS_ACT;
            vsync      <= vs_p0 ? VS_ACT : ~VS_ACT;
            display_on <= vis_p0;
            hpos       <= h_cnt;
            vpos       <= v_cnt;
            red        <= red_p0;
            green      <= green_p0;
            blue       <= blue_p0;
         end
      end
   end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: a default-timing instance for line timing, colour bars and reset,
// and a reduced-timing instance for frame timing, mode latching, patterns and scrolling.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst_a, rst_b;
   logic [1:0] mode_a, mode_b;
   logic       hsync_a, vsync_a, don_a, fs_a;
   logic       hsync_b, vsync_b, don_b, fs_b;
   logic [9:0] hpos_a, vpos_a, hpos_b, vpos_b;
   logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b;

   vga_pattern_gen u_dut_a (
      .clk(clk), .reset(rst_a), .mode(mode_a),
      .hsync(hsync_a), .vsync(vsync_a), .display_on(don_a),
      .hpos(hpos_a), .vpos(vpos_a),
      .red(r_a), .green(g_a), .blue(b_a), .frame_start(fs_a)
   );

   vga_pattern_gen #(
      .CLK_DIV(1), .COLOR_BITS(4),
      .H_DISPLAY(32), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
      .V_DISPLAY(16), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
      .HSYNC_POL(0), .VSYNC_POL(0), .CHECK_SHIFT(3)
   ) u_dut_b (
      .clk(clk), .reset(rst_b), .mode(mode_b),
      .hsync(hsync_b), .vsync(vsync_b), .display_on(don_b),
      .hpos(hpos_b), .vpos(vpos_b),
      .red(r_b), .green(g_b), .blue(b_b), .frame_start(fs_b)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int rgb_a();
      return int'({r_a, g_a, b_a});
   endfunction

   function automatic int rgb_b();
      return int'({r_b, g_b, b_b});
   endfunction

   task automatic wait_pix(input bit sel, input int hx, input int vy, input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         if (sel) hit = (int'(hpos_b) == hx) && (int'(vpos_b) == vy);
         else     hit = (int'(hpos_a) == hx) && (int'(vpos_a) == vy);
      end
      if (!hit) chk($sformatf("timeout_pix_%0d_%0d", hx, vy), 0, 1);
   endtask

   task automatic wait_fs_b(input int budget);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         @(negedge clk);
         hit = fs_b;
      end
      if (!hit) chk("timeout_frame_start", 0, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      int  rel, t_fall, f0, f1, r0, d_up, d_dn, fs_hi, fs_at, s0, s1, bad;
      logic ph, pd;
      rst_a  = 1'b1;
      rst_b  = 1'b1;
      mode_a = 2'd0;
      mode_b = 2'd0;
      repeat (3) @(negedge clk);

      chk("rst_hsync", hsync_a, 1);
      chk("rst_vsync", vsync_a, 1);
      chk("rst_display_on", don_a, 0);
      chk("rst_hpos", hpos_a, 0);
      chk("rst_vpos", vpos_a, 0);
      chk("rst_rgb", rgb_a(), 0);
      chk("rst_frame_start", fs_a, 0);
      chk("rst_vsync_b", vsync_b, 1);

      // Horizontal timing on the default instance.
      rst_a = 1'b0;
      rel   = cyc;
      f0 = -1; f1 = -1; r0 = -1; d_up = -1; d_dn = -1; fs_hi = 0; fs_at = -1;
      ph = hsync_a;
      pd = don_a;
      for (int i = 0; i < 3 * 3200; i++) begin
         @(negedge clk);
         if (ph && !hsync_a) begin
            if (f0 < 0) f0 = cyc;
            else if (f1 < 0) f1 = cyc;
         end
         if (!ph && hsync_a && r0 < 0) r0 = cyc;
         if (!pd && don_a && d_up < 0) d_up = cyc;
         if (pd && !don_a && d_dn < 0) d_dn = cyc;
         if (fs_a) begin
            fs_hi++;
            if (fs_at < 0) fs_at = cyc;
         end
         ph = hsync_a;
         pd = don_a;
      end
      chk("h_first_fall", f0 - rel, 2628);
      chk("h_period", f1 - f0, 3200);
      chk("h_low_width", r0 - f0, 384);
      chk("first_tick", d_up - rel, 4);
      chk("display_on_width", d_dn - d_up, 2560);
      chk("frame_start_clks", fs_hi, 1);
      chk("frame_start_at", fs_at - rel, 4);
      chk("vsync_idle", vsync_a, 1);

      // Colour bars on row 10.
      wait_pix(1'b0, 0, 10, 40000);
      chk("bars_0", rgb_a(), 0);
      chk("bars_0_display_on", don_a, 1);
      wait_pix(1'b0, 80, 10, 1000);
      chk("bars_80", rgb_a(), 'hF00);
      wait_pix(1'b0, 160, 10, 1000);
      chk("bars_160", rgb_a(), 'h0F0);
      wait_pix(1'b0, 639, 10, 3000);
      chk("bars_639", rgb_a(), 'hFFF);
      wait_pix(1'b0, 700, 10, 1000);
      chk("bars_700", rgb_a(), 0);
      chk("bars_700_display_on", don_a, 0);
      chk("hsync_active_700", hsync_a, 0);

      // Asynchronous reset in the middle of the sync pulse.
      #1 rst_a = 1'b1;
      #1;
      chk("async_hsync", hsync_a, 1);
      chk("async_vsync", vsync_a, 1);
      chk("async_hpos", hpos_a, 0);
      chk("async_vpos", vpos_a, 0);
      chk("async_rgb", rgb_a(), 0);
      @(negedge clk);
      rst_a  = 1'b0;
      rel    = cyc;
      t_fall = -1;
      for (int i = 0; i < 4000 && t_fall < 0; i++) begin
         @(negedge clk);
         if (!hsync_a) t_fall = cyc;
      end
      chk("restart_first_fall", t_fall - rel, 2628);

      // Vertical timing and frame_start on the reduced instance (40 x 22 clocks per frame).
      @(negedge clk);
      rst_b = 1'b0;
      rel   = cyc;
      f0 = -1; f1 = -1; r0 = -1; s0 = -1; s1 = -1; bad = 0;
      ph = vsync_b;
      for (int i = 0; i < 2 * 880 + 20; i++) begin
         @(negedge clk);
         if (ph && !vsync_b) begin
            if (f0 < 0) f0 = cyc;
            else if (f1 < 0) f1 = cyc;
         end
         if (!ph && vsync_b && r0 < 0) r0 = cyc;
         if (fs_b) begin
            if (s0 < 0) s0 = cyc;
            else if (s1 < 0) s1 = cyc;
            if (hpos_b != 10'd0 || vpos_b != 10'd0) bad++;
         end
         ph = vsync_b;
      end
      chk("v_first_fall", f0 - rel, 721);
      chk("v_period", f1 - f0, 880);
      chk("v_low_width", r0 - f0, 80);
      chk("fs_first", s0 - rel, 1);
      chk("fs_period", s1 - s0, 880);
      chk("fs_not_origin", bad, 0);

      // Mid-frame mode change stays on bars until the next frame.
      wait_pix(1'b1, 0, 8, 2000);
      mode_b = 2'd1;
      wait_pix(1'b1, 8, 10, 2000);
      chk("latch_bars_kept", rgb_b(), 'h0F0);
      wait_fs_b(2000);
      chk("checker_0_0", rgb_b(), 0);
      wait_pix(1'b1, 8, 0, 100);
      chk("checker_8_0", rgb_b(), 'hFFF);
      wait_pix(1'b1, 8, 8, 1000);
      chk("checker_8_8", rgb_b(), 0);

      mode_b = 2'd2;
      wait_fs_b(2000);
      wait_pix(1'b1, 20, 3, 1000);
      chk("gradient_20_3", rgb_b(), 'h101);

      mode_b = 2'd3;
      wait_fs_b(2000);
      wait_pix(1'b1, 5, 5, 1000);
      chk("grid_5_5", rgb_b(), 0);
      wait_pix(1'b1, 16, 5, 100);
      chk("grid_16_5", rgb_b(), 'hFFF);
      wait_pix(1'b1, 31, 5, 100);
      chk("grid_31_5", rgb_b(), 'hFFF);
      wait_pix(1'b1, 35, 5, 100);
      chk("grid_blank_35_5", rgb_b(), 0);
      chk("grid_blank_display_on", don_b, 0);
      wait_pix(1'b1, 5, 15, 1000);
      chk("grid_5_15", rgb_b(), 'hFFF);

      // Scrolling checker: frame n uses x = hpos + n when the feature is built in.
      @(negedge clk);
      rst_b  = 1'b1;
      mode_b = 2'd1;
      @(negedge clk);
      rst_b = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         wait_fs_b(2000);
         if (k == 1) chk("scroll_frame1", rgb_b(), 0);
         if (k == 8) begin
`ifdef VGA_PATTERN_SCROLL_EN
            chk("scroll_frame8", rgb_b(), 'hFFF);
`else
            chk("scroll_frame8", rgb_b(), 0);
`endif
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
